// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling constants and frame width.
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rxState_e;

  // Oversampling: 16 ticks per bit, decide mid start bit, sample data on the last tick
  localparam int         SAMPLES   = 16;
  localparam logic [3:0] MID       = 4'(SAMPLES / 2 - 1);
  localparam logic [3:0] LAST      = 4'(SAMPLES - 1);

  // Payload bits per frame (8N1)
  localparam int         DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with push/pop handshake. A pop on an empty
// FIFO is ignored; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle, otherwise it is flagged as dropped.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = CNT_ONE << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  doPush;
  logic                  doPop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rdPtr_q];
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign dropped = push && !doPush;

  // Next pointer and occupancy values from the accepted push/pop pair
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    if (doPush && !doPop)      count_d = count_q + CNT_ONE;
    else if (doPop && !doPush) count_d = count_q - CNT_ONE;
  end

  // Storage and pointer registers; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) mem_q[wrPtr_q] <= wdata;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receive front end: two-flop input synchronizer, free-running
// 16x oversample tick, frame FSM, byte FIFO and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 130,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam logic [15:0] TICK_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rsMeta_q, rs_q;
  logic [15:0]          tickCnt_q, tickCnt_d;
  logic                 tick;
  rxState_e             state_q, state_d;
  logic [3:0]           sc_q, sc_d;
  logic [2:0]           bi_q, bi_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pushByte;
  logic                 frameErrSet;
  logic                 dropped;
  logic                 fifoEmpty;
  logic                 overrun_q, overrun_d;
  logic                 frameErr_q, frameErr_d;

  // Bring the asynchronous serial line into the clock domain; idle level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsMeta_q <= 1'b1;
      rs_q     <= 1'b1;
    end else begin
      rsMeta_q <= rxd;
      rs_q     <= rsMeta_q;
    end
  end

  // Free-running oversample divider; it never resyncs to a start edge
  assign tick      = (tickCnt_q == TICK_LAST);
  assign tickCnt_d = tick ? 16'd0 : tickCnt_q + 16'd1;

  // Divider register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tickCnt_q <= '0;
    else       tickCnt_q <= tickCnt_d;
  end

  // Frame FSM: all decisions are taken on oversample ticks only
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    bi_d        = bi_q;
    shift_d     = shift_q;
    pushByte    = 1'b0;
    frameErrSet = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rs_q) begin
            state_d = START;
            sc_d    = '0;
          end
        end
        START: begin
          if (sc_q == MID) begin
            if (rs_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              sc_d    = '0;
              bi_d    = '0;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        DATA: begin
          if (sc_q == LAST) begin
            shift_d = {rs_q, shift_q[DATA_BITS-1:1]};
            sc_d    = '0;
            if (bi_q == LAST_BIT) state_d = STOP;
            else                  bi_d    = bi_q + 3'd1;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        STOP: begin
          if (sc_q == LAST) begin
            sc_d = '0;
            if (rs_q) begin
              pushByte = 1'b1;
              state_d  = IDLE;
            end else begin
              frameErrSet = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        BREAK: begin
          if (rs_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, sample count, bit index and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      shift_q <= shift_d;
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (pushByte),
    .pop     (rd_en),
    .wdata   (shift_q),
    .rdata   (rx_data),
    .full    (rx_full),
    .empty   (fifoEmpty),
    .dropped (dropped)
  );

  assign rx_valid = !fifoEmpty;

  // Sticky flags: a new error in the same cycle as a clear leaves the flag set
  always_comb begin
    overrun_d  = (overrun_q  && !clr_err) || dropped;
    frameErr_d = (frameErr_q && !clr_err) || frameErrSet;
  end

  // Error flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with BAUD_DIV=4 (64 clk per bit).
// Expected bytes and flags come from a queue-based model of the FIFO.
module tb_uart_rx_fifo;

  localparam int BAUD     = 4;
  localparam int BIT_CLKS = 16 * BAUD;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;

  int         nAssert = 0;
  int         nFail   = 0;
  int         cyc;
  logic [7:0] expQ[$];
  logic       expOverrun = 1'b0;

  uart_rx_fifo #(
    .BAUD_DIV   (BAUD),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_full   (rx_full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  // 100 MHz-style free clock
  always #5 clk = ~clk;

  // Count rising edges since reset release, to locate oversample ticks
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // One comparison point
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idleLine(input int n);
    rxd = 1'b1;
    waitNeg(n);
  endtask

  task automatic pulseClear();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    expOverrun = 1'b0;
  endtask

  // Pop the head byte and compare it against the model
  task automatic popByte(input string tag);
    logic [7:0] exp;
    checkOutput({tag, "_valid"}, 8'(rx_valid), 8'd1);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
    checkOutput({tag, "_data"}, rx_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Send one 8N1 frame starting at a falling clock edge. The stop-bit sample
  // edge is predicted from the free-running tick: first tick at least 3
  // edges after the start edge, then 8 + 16*9 ticks to the stop sample.
  // Leaves rxd at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] data, input logic stopHigh,
                               input logic latCheck, input logic popAtPush);
    int         t0;
    int         pushCyc;
    logic [9:0] frame;
    logic       preValid;
    frame    = {stopHigh, data, 1'b0};
    preValid = (expQ.size() > 0);
    t0 = cyc + 3;
    while (t0 % BAUD != 0) t0++;
    pushCyc = t0 + (8 + 16 * 9) * BAUD;
    for (int b = 0; b < 10; b++) begin
      rxd = frame[b];
      for (int k = 0; k < BIT_CLKS; k++) begin
        if (b == 9 && cyc == pushCyc - 1) begin
          if (latCheck) checkOutput("lat_before_push", 8'(rx_valid), 8'(preValid));
          if (popAtPush) begin
            checkOutput("popAtPush_full", 8'(rx_full), 8'd1);
            checkOutput("popAtPush_head", rx_data, (expQ.size() > 0) ? expQ[0] : 8'h00);
            rd_en = 1'b1;
          end
        end
        if (b == 9 && cyc == pushCyc) begin
          if (latCheck) checkOutput("lat_after_push", 8'(rx_valid), 8'd1);
          rd_en = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (stopHigh) begin
      if (popAtPush && expQ.size() > 0) void'(expQ.pop_front());
      if (expQ.size() < DEPTH) expQ.push_back(data);
      else                     expOverrun = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rnd;
    logic [7:0] partial;
    int         nPop;

    reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    waitNeg(3);
    checkOutput("reset_valid",    8'(rx_valid),  8'd0);
    checkOutput("reset_data",     rx_data,       8'h00);
    checkOutput("reset_full",     8'(rx_full),   8'd0);
    checkOutput("reset_overrun",  8'(overrun),   8'd0);
    checkOutput("reset_frameerr", 8'(frame_err), 8'd0);
    reset = 1'b0;
    idleLine(10);

    // Two frames, latency checked around each stop sample, then drain
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
    idleLine(20);
    applyStimulus(8'hA3, 1'b1, 1'b1, 1'b0);
    idleLine(20);
    popByte("basic0");
    popByte("basic1");
    checkOutput("basic_empty", 8'(rx_valid), 8'd0);

    // Five frames into a four-deep FIFO without reads
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
      idleLine(16);
    end
    checkOutput("ovr_full",    8'(rx_full), 8'd1);
    checkOutput("ovr_flag",    8'(overrun), 8'(expOverrun));
    for (int i = 0; i < 4; i++) popByte("ovr_pop");
    checkOutput("ovr_empty",   8'(rx_valid), 8'd0);
    checkOutput("ovr_notfull", 8'(rx_full),  8'd0);
    checkOutput("ovr_sticky",  8'(overrun),  8'd1);
    pulseClear();
    checkOutput("ovr_cleared", 8'(overrun), 8'd0);

    // Low stop bit, then line held low: one error event only
    applyStimulus(8'h7E, 1'b0, 1'b0, 1'b0);
    waitNeg(20);
    checkOutput("ferr_set",   8'(frame_err), 8'd1);
    checkOutput("ferr_nobyte", 8'(rx_valid), 8'd0);
    waitNeg(200);
    pulseClear();
    waitNeg(180);
    checkOutput("ferr_break_quiet", 8'(frame_err), 8'd0);
    idleLine(40);
    applyStimulus(8'h10, 1'b1, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("ferr_single", 8'(frame_err), 8'd0);
    popByte("ferr_after");
    checkOutput("ferr_empty", 8'(rx_valid), 8'd0);

    // Start-bit glitch shorter than half a bit
    rxd = 1'b0;
    waitNeg(20);
    idleLine(700);
    checkOutput("glitch_nobyte",  8'(rx_valid),  8'd0);
    checkOutput("glitch_noferr",  8'(frame_err), 8'd0);
    checkOutput("glitch_noovr",   8'(overrun),   8'd0);

    // Fill, then pop on the exact cycle 0x33 is pushed
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      idleLine(12);
    end
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1);
    idleLine(12);
    checkOutput("pp_noovr", 8'(overrun), 8'd0);
    checkOutput("pp_full",  8'(rx_full), 8'd1);
    for (int i = 0; i < 4; i++) popByte("pp_pop");
    checkOutput("pp_empty", 8'(rx_valid), 8'd0);

    // Random bytes with random reads in the gaps
    for (int i = 0; i < 10; i++) begin
      rnd = 8'($urandom_range(0, 255));
      applyStimulus(rnd, 1'b1, 1'b1, 1'b0);
      idleLine($urandom_range(5, 60));
      nPop = $urandom_range(0, 2);
      for (int p = 0; p < nPop; p++) begin
        if (expQ.size() > 0) popByte("rnd_pop");
      end
    end
    checkOutput("rnd_overrun", 8'(overrun), 8'(expOverrun));
    while (expQ.size() > 0) popByte("rnd_drain");
    checkOutput("rnd_empty", 8'(rx_valid), 8'd0);
    pulseClear();

    // Reset in the middle of a data bit
    applyStimulus(8'h99, 1'b1, 1'b0, 1'b0);
    idleLine(10);
    applyStimulus(8'h66, 1'b0, 1'b0, 1'b0);
    idleLine(20);
    checkOutput("prerst_ferr",  8'(frame_err), 8'd1);
    checkOutput("prerst_valid", 8'(rx_valid),  8'd1);
    partial = 8'hC3;
    rxd = 1'b0;
    waitNeg(BIT_CLKS);
    for (int b = 0; b < 4; b++) begin
      rxd = partial[b];
      waitNeg(BIT_CLKS);
    end
    reset = 1'b1;
    #1;
    checkOutput("rst_valid", 8'(rx_valid),  8'd0);
    checkOutput("rst_data",  rx_data,       8'h00);
    checkOutput("rst_full",  8'(rx_full),   8'd0);
    checkOutput("rst_ovr",   8'(overrun),   8'd0);
    checkOutput("rst_ferr",  8'(frame_err), 8'd0);
    expQ.delete();
    expOverrun = 1'b0;
    rxd = 1'b1;
    waitNeg(5);
    reset = 1'b0;
    idleLine(10);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);
    idleLine(10);
    popByte("postrst");
    checkOutput("postrst_empty", 8'(rx_valid),  8'd0);
    checkOutput("postrst_ferr",  8'(frame_err), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
